// File: rtl/spi_arb_pkg.sv
// Shared types and elaboration-time helpers for the SPI bus arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  // Smallest phase counter must still hold the 4-bit setup/hold/gap counts.
  localparam int unsigned PHASE_MIN_CNT = 15;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while (((32'(1) << r) < v) && (r < 31)) begin
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Phase counter width: must reach max(2*DATA_W, 15).
  function automatic int unsigned phase_w(input int unsigned data_w);
    int unsigned m;
    m = ((2 * data_w) > PHASE_MIN_CNT) ? (2 * data_w) : PHASE_MIN_CNT;
    return clog2(m + 1);
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_arbiter.sv
// Combinational requester picker: round-robin from last+1, or fixed
// lowest-index priority when SPI_ARB_FIXED_PRIORITY_EN is defined.
module rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] win_c,
  output logic [IDX_W-1:0]   win_idx_c
);

`ifdef SPI_ARB_FIXED_PRIORITY_EN
  logic found;
  logic unused_last;

  assign unused_last = ^last;

  always_comb begin
    win_c     = '0;
    win_idx_c = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req[IDX_W'(i)]) begin
        found                = 1'b1;
        win_c[IDX_W'(i)]     = 1'b1;
        win_idx_c            = IDX_W'(i);
      end
    end
  end
`else
  logic             found;
  logic [IDX_W-1:0] idx;

  // Scan upward from the requester after the last owner, wrapping round.
  always_comb begin
    win_c     = '0;
    win_idx_c = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((32'(last) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        win_c[idx] = 1'b1;
        win_idx_c  = idx;
      end
    end
  end
`endif

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI mode-0 master between NUM_REQ requesters (clk16 domain).
// Define SPI_ARB_FIXED_PRIORITY_EN for fixed lowest-index priority.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned CS_SETUP = 1,
  parameter int unsigned CS_HOLD  = 1,
  parameter int unsigned IDLE_GAP = 2
) (
  input  logic                      clk16,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] tx_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      busy,
  output logic                      sclk,
  output logic                      mosi,
  input  logic                      miso,
  output logic [NUM_REQ-1:0]        cs_n
);

  localparam int unsigned IDX_W = clog2(NUM_REQ);
  localparam int unsigned CNT_W = phase_w(DATA_W);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  req_q;
  logic [NUM_REQ-1:0]  req_eff_c;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic                busy_q, busy_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [NUM_REQ-1:0]  cs_n_q, cs_n_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [NUM_REQ-1:0]  win_c;
  logic [IDX_W-1:0]    win_idx_c;
  logic [DATA_W-1:0]   tx_sel_c;
  logic                launch_c;

  // A request must be seen on two consecutive edges, so a requester that
  // drops req on its done pulse is never granted again from stale state.
  assign req_eff_c = req & req_q;
  assign tx_sel_c  = tx_data[32'(win_idx_c) * DATA_W +: DATA_W];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (req_eff_c),
    .last      (last_q),
    .win_c     (win_c),
    .win_idx_c (win_idx_c)
  );

  // State and output registers.
  always_ff @(posedge clk16) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      grant_q <= '0;
      done_q  <= '0;
      rx_q    <= '0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= '1;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req;
      last_q  <= last_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      rx_q    <= rx_d;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      shift_q <= shift_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    grant_d  = grant_q;
    done_d   = '0;
    rx_d     = rx_q;
    busy_d   = busy_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    cs_n_d   = cs_n_q;
    shift_d  = shift_q;
    launch_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req_eff_c) begin
          launch_c = 1'b1;
        end
      end

      ST_SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Rising SCLK samples miso into the LSB; falling SCLK presents next MSB.
      ST_SHIFT: begin
        sclk_d = ~sclk_q;
        if (!sclk_q) begin
          shift_d = {shift_q[DATA_W-2:0], miso};
        end else if (cnt_q != CNT_W'(2 * DATA_W - 1)) begin
          mosi_d = shift_q[DATA_W-1];
        end
        if (cnt_q == CNT_W'(2 * DATA_W - 1)) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          cs_n_d  = '1;
          grant_d = '0;
          done_d  = grant_q;
          rx_d    = shift_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Back-to-back transfers launch straight from the end of the gap.
      ST_GAP: begin
        if (cnt_q == CNT_W'(IDLE_GAP - 1)) begin
          cnt_d = '0;
          if (|req_eff_c) begin
            launch_c = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (launch_c) begin
      state_d = ST_SETUP;
      cnt_d   = '0;
      grant_d = win_c;
      cs_n_d  = ~win_c;
      busy_d  = 1'b1;
      shift_d = tx_sel_c;
      mosi_d  = tx_sel_c[DATA_W-1];
      last_d  = win_idx_c;
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign rx_data = rx_q;
  assign busy    = busy_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with miso looped back to mosi.
module tb_spi_bus_arbiter;

  logic        clk16;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] tx_data;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [15:0] rx_data;
  logic        busy;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic [3:0]  cs_n;

  int checks;
  int failures;
  int rr_order [5];
  int fair_order [4];

  assign miso = mosi;

  spi_bus_arbiter dut (
    .clk16   (clk16),
    .rst     (rst),
    .req     (req),
    .tx_data (tx_data),
    .grant   (grant),
    .done    (done),
    .rx_data (rx_data),
    .busy    (busy),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso),
    .cs_n    (cs_n)
  );

  initial clk16 = 1'b0;
  always #5 clk16 = ~clk16;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk16);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input int i);
    return tx_data[i*16 +: 16];
  endfunction

  // Waits for a chip select, then follows one whole transfer to its done pulse.
  task automatic xfer(input int idx, input logic [15:0] exp_word, input int exp_lat,
                      input bit chg_tx, input bit drop_req);
    int          lat;
    int          t;
    int          pulses;
    logic [15:0] word;
    logic        prev;
    logic [3:0]  oh;
    logic [3:0]  exp_cs;
    oh     = 4'(4'b0001 << idx);
    exp_cs = ~oh;
    lat    = 0;
    while (cs_n === 4'hF && lat < 50) begin
      tick();
      lat++;
    end
    chk("grant_latency", 32'(lat), 32'(exp_lat));
    chk("grant_onehot", 32'(grant), 32'(oh));
    chk("cs_n_active", 32'(cs_n), 32'(exp_cs));
    chk("busy_at_grant", 32'(busy), 32'd1);
    if (drop_req) req[idx] = 1'b0;
    prev   = sclk;
    pulses = 0;
    word   = '0;
    t      = 0;
    while (done === 4'b0000 && t < 60) begin
      tick();
      t++;
      if (!prev && sclk) begin
        pulses++;
        word = {word[14:0], mosi};
      end
      prev = sclk;
      if (chg_tx && t == 10) tx_data[15:0] = 16'hFFFF;
    end
    chk("done_delay", 32'(t), 32'd34);
    chk("done_onehot", 32'(done), 32'(oh));
    chk("sclk_pulses", 32'(pulses), 32'd16);
    chk("mosi_word", 32'(word), 32'(exp_word));
    chk("rx_data", 32'(rx_data), 32'(exp_word));
    chk("cs_n_release", 32'(cs_n), 32'hF);
    chk("grant_release", 32'(grant), 32'd0);
  endtask

  initial begin
    int  lat;
    int  pulses;
    logic prev;
    bit  done_seen;

    checks   = 0;
    failures = 0;
`ifdef SPI_ARB_FIXED_PRIORITY_EN
    rr_order   = '{0, 0, 0, 0, 0};
    fair_order = '{1, 1, 1, 1};
`else
    rr_order   = '{0, 1, 2, 3, 0};
    fair_order = '{1, 3, 1, 3};
`endif
    rst     = 1'b1;
    req     = 4'b0000;
    tx_data = '0;
    tick(3);

    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx", 32'(rx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_cs_n", 32'(cs_n), 32'hF);
    rst = 1'b0;
    tick();

    // Reset during the fifth SCLK pulse of a transfer.
    tx_data[15:0] = 16'hBEEF;
    req = 4'b0001;
    lat = 0;
    while (cs_n === 4'hF && lat < 50) begin
      tick();
      lat++;
    end
    chk("midrst_cs_low", 32'(cs_n), 32'hE);
    prev   = sclk;
    pulses = 0;
    lat    = 0;
    while (pulses < 5 && lat < 60) begin
      tick();
      lat++;
      if (!prev && sclk) pulses++;
      prev = sclk;
    end
    chk("midrst_pulse5_high", 32'(sclk), 32'd1);
    rst = 1'b1;
    req = 4'b0000;
    tick();
    chk("midrst_cs_n", 32'(cs_n), 32'hF);
    chk("midrst_sclk", 32'(sclk), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_rx", 32'(rx_data), 32'd0);
    rst = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done !== 4'b0000) done_seen = 1'b1;
    end
    chk("midrst_no_done", 32'(done_seen), 32'd0);
    chk("midrst_idle_cs", 32'(cs_n), 32'hF);

    // Single transfer from requester 2.
    tx_data[47:32] = 16'hA5C3;
    req = 4'b0100;
    xfer(2, 16'hA5C3, 2, 1'b0, 1'b0);
    req = 4'b0000;
    tick();
    chk("gap_busy_high", 32'(busy), 32'd1);
    tick();
    chk("gap_busy_low", 32'(busy), 32'd0);
    tick(3);

    // Round-robin with all four requesting, starting from a fresh pointer.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tx_data = {16'h0000, 16'hFFFF, 16'h7FFE, 16'h8001};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      xfer(rr_order[k], word_of(rr_order[k]), 2, 1'b0, 1'b0);
    end

    // Two contenders must alternate.
    req = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      xfer(fair_order[k], word_of(fair_order[k]), 2, 1'b0, 1'b0);
    end
    req = 4'b0000;
    tick(5);

    // Word is captured at grant; the following transfer picks up the new one.
    tx_data[15:0] = 16'h1234;
    req = 4'b0001;
    xfer(0, 16'h1234, 2, 1'b1, 1'b0);
    xfer(0, 16'hFFFF, 2, 1'b0, 1'b0);
    req = 4'b0000;
    tick(5);

    // Dropping req during setup still completes, then no further grant.
    tx_data[15:0] = 16'h0F0F;
    req = 4'b0001;
    xfer(0, 16'h0F0F, 2, 1'b0, 1'b1);
    tick(10);
    chk("drop_no_regrant_cs", 32'(cs_n), 32'hF);
    chk("drop_no_regrant_grant", 32'(grant), 32'd0);
    chk("drop_idle_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
